// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state enum and opcode classification for the ALU issue controller
// Purpose: one place for instruction field positions, opcode values, FSM state
//          encoding and the opcode classification helpers used by decode and top.
// Ports:   none (package).
package alu_pkg;

  localparam int DATA_W  = 72;
  localparam int INSTR_W = 60;
  localparam int REG_AW  = 4;
  localparam int PC_W    = 16;
  localparam int IMM_W   = 44;

  // Instruction field bit positions.
  localparam int OP_HI  = 59;
  localparam int OP_LO  = 56;
  localparam int RD_HI  = 55;
  localparam int RD_LO  = 52;
  localparam int RS1_HI = 51;
  localparam int RS1_LO = 48;
  localparam int RS2_HI = 47;
  localparam int RS2_LO = 44;
  localparam int IMM_HI = 43;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SUBI = 4'd6;
  localparam logic [3:0] OP_ANDI = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_BLT  = 4'd13;
  localparam logic [3:0] OP_BGT  = 4'd14;
  localparam logic [3:0] OP_J    = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2,
    WB   = 2'd3
  } state_e;

  // Operand B comes from the immediate rather than rs2.
  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_ANDI) || (op == OP_J);
  endfunction

  // Produces a branch/jump outcome instead of a register write.
  function automatic logic is_branch_op(input logic [3:0] op);
    return op >= OP_BEQ;
  endfunction

  // Writes its result back to the register file.
  function automatic logic is_wb_op(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - combinational instruction field decode
// Purpose: split a latched instruction into its fields and classify the opcode.
// Ports:   instr_i      instruction word
//          op_o/rd_o/rs1_o/rs2_o  raw fields
//          imm_ext_o    imm zero-extended to DATA_W
//          use_imm_o    operand B is the immediate
//          is_branch_o  ops 11-15 (branch outcome reported)
//          is_jump_o    op 15 (always taken)
//          writes_rf_o  ops 0-10 (result written back)
module alu_instr_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         op_o,
  output logic [REG_AW-1:0]  rd_o,
  output logic [REG_AW-1:0]  rs1_o,
  output logic [REG_AW-1:0]  rs2_o,
  output logic [DATA_W-1:0]  imm_ext_o,
  output logic               use_imm_o,
  output logic               is_branch_o,
  output logic               is_jump_o,
  output logic               writes_rf_o
);

  assign op_o        = instr_i[OP_HI:OP_LO];
  assign rd_o        = instr_i[RD_HI:RD_LO];
  assign rs1_o       = instr_i[RS1_HI:RS1_LO];
  assign rs2_o       = instr_i[RS2_HI:RS2_LO];
  assign imm_ext_o   = {{(DATA_W-IMM_W){1'b0}}, instr_i[IMM_HI:IMM_LO]};
  assign use_imm_o   = is_imm_op(op_o);
  assign is_branch_o = is_branch_op(op_o);
  assign is_jump_o   = (op_o == OP_J);
  assign writes_rf_o = is_wb_op(op_o);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - four-state issue controller in front of a registered ALU
// Purpose: accept one instruction, read its operands, drive the ALU, then either
//          write the result back or report a branch/jump outcome.
// Ports:   clk, rst                     clock, async active-high reset
//          instr_valid/instr/instr_ready instruction handshake (ready only in IDLE)
//          rf_ra1/rf_ra2, rf_rd1/rf_rd2  register-file read (combinational data)
//          alu_op/alu_a/alu_b, alu_c     ALU drive / registered ALU result
//          rf_we/rf_wa/rf_wd            write-back pulse
//          br_valid/br_taken/br_target  branch-outcome pulse
//          div_zero                     pulse for divide by zero
//          busy                         not IDLE
module alu_issue_ctrl #(
  parameter int DATA_W  = 72,
  parameter int INSTR_W = 60,
  parameter int REG_AW  = 4,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [REG_AW-1:0]  rf_ra1,
  output logic [REG_AW-1:0]  rf_ra2,
  input  logic [DATA_W-1:0]  rf_rd1,
  input  logic [DATA_W-1:0]  rf_rd2,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_c,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_wa,
  output logic [DATA_W-1:0]  rf_wd,
  output logic               br_valid,
  output logic               br_taken,
  output logic [PC_W-1:0]    br_target,
  output logic               div_zero,
  output logic               busy
);
  import alu_pkg::*;

  state_e              state_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                ready_q;
  logic                busy_q;
  logic [3:0]          alu_op_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic [DATA_W-1:0]   alu_b_d;
  logic                rf_we_q;
  logic [REG_AW-1:0]   rf_wa_q;
  logic                br_valid_q;
  logic                is_jump_q;
  logic [PC_W-1:0]     br_target_q;
  logic                div_zero_q;

  logic [3:0]          dec_op;
  logic [REG_AW-1:0]   dec_rd;
  logic [REG_AW-1:0]   dec_rs1;
  logic [REG_AW-1:0]   dec_rs2;
  logic [DATA_W-1:0]   dec_imm;
  logic                dec_use_imm;
  logic                dec_is_branch;
  logic                dec_is_jump;
  logic                dec_writes_rf;

  alu_instr_decode #(.DATA_W(DATA_W)) u_decode (
    .instr_i     (instr_q),
    .op_o        (dec_op),
    .rd_o        (dec_rd),
    .rs1_o       (dec_rs1),
    .rs2_o       (dec_rs2),
    .imm_ext_o   (dec_imm),
    .use_imm_o   (dec_use_imm),
    .is_branch_o (dec_is_branch),
    .is_jump_o   (dec_is_jump),
    .writes_rf_o (dec_writes_rf)
  );

  assign alu_b_d = dec_use_imm ? dec_imm : rf_rd2;

  // The outcome is decided on the EX->WB edge and registered as a pulse, but
  // alu_c only becomes valid during WB, so data-dependent outputs are gated
  // from it here rather than registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      br_valid_q  <= 1'b0;
      is_jump_q   <= 1'b0;
      br_target_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      rf_we_q    <= 1'b0;
      br_valid_q <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: begin
          alu_op_q <= dec_op;
          alu_a_q  <= rf_rd1;
          alu_b_q  <= alu_b_d;
          state_q  <= EX;
        end
        EX: begin
          rf_wa_q     <= dec_rd;
          br_target_q <= dec_imm[PC_W-1:0];
          is_jump_q   <= dec_is_jump;
          br_valid_q  <= dec_is_branch;
          if (dec_writes_rf) begin
            if ((dec_op == OP_DIV) && (alu_b_q == '0)) begin
              div_zero_q <= 1'b1;
            end else if (dec_rd != '0) begin
              rf_we_q <= 1'b1;
            end
          end
          state_q <= WB;
        end
        WB: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign rf_ra1      = dec_rs1;
  assign rf_ra2      = dec_rs2;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rf_we       = rf_we_q;
  assign rf_wa       = rf_wa_q;
  assign rf_wd       = rf_we_q ? alu_c : '0;
  assign br_valid    = br_valid_q;
  assign br_taken    = br_valid_q & (is_jump_q | alu_c[0]);
  assign br_target   = br_target_q;
  assign div_zero    = div_zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [59:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rf_ra1, rf_ra2;
  logic [71:0] rf_rd1, rf_rd2;
  logic [3:0]  alu_op;
  logic [71:0] alu_a, alu_b;
  logic [71:0] alu_c = '0;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [71:0] rf_wd;
  logic        br_valid, br_taken;
  logic [15:0] br_target;
  logic        div_zero, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_c(alu_c), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU semantics of the surrounding system.
  function automatic logic [71:0] alu_fn(input logic [3:0] op, input logic [71:0] a, input logic [71:0] b);
    case (op)
      4'd0, 4'd5: return a + b;
      4'd1, 4'd6: return a - b;
      4'd2:       return a * b;
      4'd3:       return (b == 0) ? 72'd0 : a / b;
      4'd4:       return a << b[6:0];
      4'd7, 4'd8: return a & b;
      4'd9:       return a | b;
      4'd10:      return a ^ b;
      4'd11:      return {71'd0, a == b};
      4'd12:      return {71'd0, a != b};
      4'd13:      return {71'd0, a < b};
      4'd14:      return {71'd0, a > b};
      default:    return 72'd0;
    endcase
  endfunction

  // Environment: register file (R0 reads zero) and registered ALU.
  logic [71:0] env_rf [16] = '{default: '0};
  logic        tb_wr_en = 1'b0;
  logic [3:0]  tb_wr_a = '0;
  logic [71:0] tb_wr_d = '0;

  assign rf_rd1 = (rf_ra1 == 4'd0) ? 72'd0 : env_rf[rf_ra1];
  assign rf_rd2 = (rf_ra2 == 4'd0) ? 72'd0 : env_rf[rf_ra2];

  always @(posedge clk) begin
    alu_c <= alu_fn(alu_op, alu_a, alu_b);
    if (tb_wr_en) env_rf[tb_wr_a] <= tb_wr_d;
    else if (rf_we && rf_wa != 4'd0) env_rf[rf_wa] <= rf_wd;
  end

  // Reference model: architectural registers and expected outcome per instruction.
  logic [71:0] ref_rf [16] = '{default: '0};
  logic        e_we, e_bv, e_bt, e_dz;
  logic [3:0]  e_wa;
  logic [71:0] e_wd, e_b;
  logic [15:0] e_tgt;

  task automatic ref_exec(input logic [59:0] ins);
    logic [3:0]  op;
    logic [43:0] imm;
    logic [71:0] a, r;
    op  = ins[59:56];
    imm = ins[43:0];
    a   = ref_rf[ins[51:48]];
    e_b = (op == 5 || op == 6 || op == 7 || op == 15) ? {28'd0, imm} : ref_rf[ins[47:44]];
    r   = alu_fn(op, a, e_b);
    e_we = 0; e_dz = 0; e_bv = 0; e_bt = 0; e_wa = ins[55:52]; e_wd = r; e_tgt = imm[15:0];
    if (op <= 10) begin
      if (op == 3 && e_b == 0) e_dz = 1;
      else if (ins[55:52] != 0) begin
        e_we = 1;
        ref_rf[ins[55:52]] = r;
      end
    end else begin
      e_bv = 1;
      e_bt = (op == 15) ? 1'b1 : r[0];
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [71:0] v);
    tb_wr_en = 1; tb_wr_a = a; tb_wr_d = v;
    ref_rf[a] = v;
    @(negedge clk);
    tb_wr_en = 0;
  endtask

  // Observations gathered around one instruction; called at a negedge.
  int          o_acc, o_stray, o_rdylow;
  bit          o_to;
  logic        o_we, o_bv, o_bt, o_dz;
  logic [3:0]  o_wa;
  logic [71:0] o_wd, o_exb;
  logic [15:0] o_tgt;

  task automatic run_instr(input logic [59:0] ins, input bit keep);
    int n;
    n = 0; o_to = 0; o_stray = 0; o_rdylow = 0;
    instr = ins; instr_valid = 1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      o_to = 1;
      instr_valid = 0;
      return;
    end
    @(posedge clk);
    #1 o_acc = cyc;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) instr_valid = 0;
      if (!instr_ready) o_rdylow++;
      if (k < 3 && (rf_we || br_valid || div_zero)) o_stray++;
      if (k == 2) o_exb = alu_b;
      if (k == 3) begin
        o_we = rf_we; o_wa = rf_wa; o_wd = rf_wd;
        o_bv = br_valid; o_bt = br_taken; o_tgt = br_target; o_dz = div_zero;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", instr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if ({rf_we, br_valid, br_taken, div_zero} !== 4'b0) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {rf_we, br_valid, br_taken, div_zero}); end
    checks++; if ({alu_op, alu_a, alu_b} !== '0) begin failures++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0", alu_op, alu_a, alu_b); end
    checks++; if ({rf_wa, rf_wd, br_target} !== '0) begin failures++; $display("FAIL rst_wb got=%0h/%0h/%0h exp=0", rf_wa, rf_wd, br_target); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_add;
    set_reg(1, 72'd5); set_reg(2, 72'd7);
    ref_exec({4'd0, 4'd3, 4'd1, 4'd2, 44'd0});
    run_instr({4'd0, 4'd3, 4'd1, 4'd2, 44'd0}, 0);
    checks++; if (o_to !== 1'b0) begin failures++; $display("FAIL add_accept got=timeout exp=accepted"); end
    checks++; if (o_we !== 1'b1 || o_wa !== 4'd3 || o_wd !== 72'd12) begin failures++; $display("FAIL add_wb got=we%0b wa%0d wd%0d exp=we1 wa3 wd12", o_we, o_wa, o_wd); end
    checks++; if (o_rdylow !== 3 || o_stray !== 0) begin failures++; $display("FAIL add_timing got=rdylow%0d stray%0d exp=rdylow3 stray0", o_rdylow, o_stray); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL add_after got=we%0b rdy%0b busy%0b exp=we0 rdy1 busy0", rf_we, instr_ready, busy); end
  endtask

  task automatic test_addi;
    set_reg(1, 72'd100);
    run_instr({4'd5, 4'd4, 4'd1, 4'd0, 44'h2A}, 0);
    checks++; if (o_exb !== 72'd42) begin failures++; $display("FAIL addi_b got=%0d exp=42", o_exb); end
    checks++; if (o_we !== 1'b1 || o_wa !== 4'd4 || o_wd !== 72'd142) begin failures++; $display("FAIL addi_wb got=we%0b wa%0d wd%0d exp=we1 wa4 wd142", o_we, o_wa, o_wd); end
    ref_rf[4] = 72'd142;
    @(negedge clk);
  endtask

  task automatic test_branch;
    set_reg(1, 72'd9); set_reg(2, 72'd9);
    run_instr({4'd11, 4'd0, 4'd1, 4'd2, 44'h0040}, 0);
    checks++; if (o_bv !== 1'b1 || o_bt !== 1'b1 || o_tgt !== 16'h0040 || o_we !== 1'b0) begin failures++; $display("FAIL beq_taken got=bv%0b bt%0b tgt%0h we%0b exp=bv1 bt1 tgt40 we0", o_bv, o_bt, o_tgt, o_we); end
    @(negedge clk);
    set_reg(2, 72'd8);
    run_instr({4'd11, 4'd0, 4'd1, 4'd2, 44'h0040}, 0);
    checks++; if (o_bv !== 1'b1 || o_bt !== 1'b0) begin failures++; $display("FAIL beq_not got=bv%0b bt%0b exp=bv1 bt0", o_bv, o_bt); end
    @(negedge clk);
    run_instr({4'd15, 4'd0, 4'd0, 4'd0, 44'h1234}, 0);
    checks++; if (o_bv !== 1'b1 || o_bt !== 1'b1 || o_tgt !== 16'h1234) begin failures++; $display("FAIL jump got=bv%0b bt%0b tgt%0h exp=bv1 bt1 tgt1234", o_bv, o_bt, o_tgt); end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    set_reg(1, 72'd50); set_reg(2, 72'd0); set_reg(5, 72'h77);
    run_instr({4'd3, 4'd5, 4'd1, 4'd2, 44'd0}, 0);
    checks++; if (o_dz !== 1'b1 || o_we !== 1'b0) begin failures++; $display("FAIL div0 got=dz%0b we%0b exp=dz1 we0", o_dz, o_we); end
    @(negedge clk);
    checks++; if (env_rf[5] !== 72'h77) begin failures++; $display("FAIL div0_r5 got=%0h exp=77", env_rf[5]); end
    run_instr({4'd1, 4'd0, 4'd1, 4'd2, 44'd0}, 0);
    checks++; if (o_we !== 1'b0 || o_dz !== 1'b0 || o_stray !== 0) begin failures++; $display("FAIL r0_write got=we%0b dz%0b stray%0d exp=we0 dz0 stray0", o_we, o_dz, o_stray); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int acc1;
    set_reg(1, 72'd5); set_reg(2, 72'd7);
    run_instr({4'd0, 4'd3, 4'd1, 4'd2, 44'd0}, 1);
    acc1 = o_acc;
    checks++; if (o_we !== 1'b1 || o_wd !== 72'd12) begin failures++; $display("FAIL b2b_first got=we%0b wd%0d exp=we1 wd12", o_we, o_wd); end
    run_instr({4'd0, 4'd6, 4'd3, 4'd3, 44'd0}, 0);
    checks++; if (o_acc - acc1 !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", o_acc - acc1); end
    checks++; if (o_we !== 1'b1 || o_wa !== 4'd6 || o_wd !== 72'd24) begin failures++; $display("FAIL b2b_raw got=we%0b wa%0d wd%0d exp=we1 wa6 wd24", o_we, o_wa, o_wd); end
    ref_rf[3] = 72'd12; ref_rf[6] = 72'd24;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int pulses;
    set_reg(1, 72'd1); set_reg(2, 72'd2); set_reg(7, 72'h55);
    instr = {4'd0, 4'd7, 4'd1, 4'd2, 44'd0}; instr_valid = 1;
    @(posedge clk);
    @(negedge clk); instr_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=rdy%0b busy%0b exp=rdy1 busy0", instr_ready, busy); end
    rst = 0;
    pulses = 0;
    repeat (5) begin
      if (rf_we || br_valid) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0 || env_rf[7] !== 72'h55) begin failures++; $display("FAIL rst_mid_abort got=pulses%0d r7=%0h exp=pulses0 r7=55", pulses, env_rf[7]); end
  endtask

  task automatic test_random;
    int prev_acc;
    bit prev_keep, keep;
    logic [59:0] ins;
    logic [3:0]  rs1;
    for (int r = 1; r < 16; r++) begin
      if ($urandom_range(0, 1) != 0) set_reg(4'(r), 72'({$urandom(), $urandom(), $urandom()}));
      else set_reg(4'(r), 72'($urandom_range(0, 7)));
    end
    prev_keep = 0; prev_acc = 0;
    for (int i = 0; i < 40; i++) begin
      rs1 = 4'($urandom_range(0, 15));
      ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rs1,
             ($urandom_range(0, 3) == 0) ? rs1 : 4'($urandom_range(0, 15)),
             44'({$urandom(), $urandom()})};
      keep = ($urandom_range(0, 1) != 0);
      ref_exec(ins);
      run_instr(ins, keep);
      checks++; if (o_to !== 1'b0) begin failures++; $display("FAIL rnd_accept i=%0d got=timeout exp=accepted", i); end
      checks++; if (o_we !== e_we || o_bv !== e_bv || o_dz !== e_dz) begin failures++; $display("FAIL rnd_kind i=%0d op=%0d got=we%0b bv%0b dz%0b exp=we%0b bv%0b dz%0b", i, ins[59:56], o_we, o_bv, o_dz, e_we, e_bv, e_dz); end
      checks++; if (o_exb !== e_b) begin failures++; $display("FAIL rnd_b i=%0d got=%0h exp=%0h", i, o_exb, e_b); end
      if (e_we) begin
        checks++; if (o_wa !== e_wa || o_wd !== e_wd) begin failures++; $display("FAIL rnd_wb i=%0d got=wa%0d wd%0h exp=wa%0d wd%0h", i, o_wa, o_wd, e_wa, e_wd); end
      end
      if (e_bv) begin
        checks++; if (o_bt !== e_bt || o_tgt !== e_tgt) begin failures++; $display("FAIL rnd_br i=%0d got=bt%0b tgt%0h exp=bt%0b tgt%0h", i, o_bt, o_tgt, e_bt, e_tgt); end
      end
      checks++; if (o_stray !== 0 || o_rdylow !== 3) begin failures++; $display("FAIL rnd_timing i=%0d got=stray%0d rdylow%0d exp=stray0 rdylow3", i, o_stray, o_rdylow); end
      if (prev_keep) begin
        checks++; if (o_acc - prev_acc !== 4) begin failures++; $display("FAIL rnd_spacing i=%0d got=%0d exp=4", i, o_acc - prev_acc); end
      end
      prev_keep = keep; prev_acc = o_acc;
    end
    instr_valid = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_addi;
    test_branch;
    test_div_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
